// File: rtl/opcode_fetch.sv
//------------------------------------------------------------------------------
// opcode_fetch : byte-wide bytecode prefetch FIFO feeding the microcode sequencer
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module opcode_fetch #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_b,
  output logic              fe__mem_req,
  output logic [ADDR_W-1:0] fe__mem_addr,
  input  logic              mem__ack,
  input  logic [7:0]        mem__data,
  output logic [7:0]        fe__opcode,
  output logic              fe__valid,
  output logic [ADDR_W-1:0] fe__pc_head,
  output logic              fe__js_mode,
  input  logic              mc__more_2a,
  input  logic              mc__operand_pop,
  input  logic              mc__stall,
  input  logic              fe__redirect,
  input  logic [ADDR_W-1:0] fe__redirect_pc,
  input  logic              fe__redirect_js
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  logic [7:0]        r_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_head_pc;
  logic [ADDR_W-1:0] r_addr;
  logic              r_js;
  logic              r_req;
  logic              r_discard;

  logic              w_valid;
  logic              w_hold;
  logic              w_pop;
  logic              w_push;
  logic [CNT_W-1:0]  w_count_next;
  logic [ADDR_W-1:0] w_fetch_pc_next;
  logic              w_req_next;
  logic [ADDR_W-1:0] w_addr_next;
  logic              w_discard_next;

  assign w_valid = (r_count != '0);
  assign w_hold  = r_req && !mem__ack;
  assign w_pop   = !fe__redirect && !mc__stall && w_valid && (!mc__more_2a || mc__operand_pop);
  assign w_push  = mem__ack && r_req && !r_discard && !fe__redirect;

  // A discarded ack belongs to the pre-redirect address, so fetch_pc (already
  // the redirect target) only advances on acks that are actually pushed.
  assign w_fetch_pc_next = fe__redirect ? fe__redirect_pc :
                           w_push       ? r_fetch_pc + ADDR_W'(1) : r_fetch_pc;

  always_comb begin
    w_count_next = r_count;
    if (fe__redirect)
      w_count_next = '0;
    else if (w_push && !w_pop)
      w_count_next = r_count + CNT_W'(1);
    else if (!w_push && w_pop)
      w_count_next = r_count - CNT_W'(1);
  end

  always_comb begin
    w_req_next     = r_req;
    w_addr_next    = r_addr;
    w_discard_next = r_discard;
    if (w_hold) begin
      if (fe__redirect)
        w_discard_next = 1'b1;
    end else if (!fe__redirect && r_discard) begin
      // Stale ack consumed: idle one cycle, then fetch from the target.
      w_req_next     = 1'b0;
      w_discard_next = 1'b0;
    end else begin
      w_req_next     = (w_count_next < C_DEPTH);
      w_addr_next    = w_fetch_pc_next;
      w_discard_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_fetch_pc <= '0;
      r_head_pc  <= '0;
      r_addr     <= '0;
      r_js       <= 1'b0;
      r_req      <= 1'b0;
      r_discard  <= 1'b0;
    end else begin
      r_count    <= w_count_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_req      <= w_req_next;
      r_addr     <= w_addr_next;
      r_discard  <= w_discard_next;
      if (w_push) begin
        r_mem[r_tail] <= mem__data;
        r_tail        <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head    <= r_head + PTR_W'(1);
        r_head_pc <= r_head_pc + ADDR_W'(1);
      end
      if (fe__redirect) begin
        r_head    <= '0;
        r_tail    <= '0;
        r_head_pc <= fe__redirect_pc;
        r_js      <= fe__redirect_js;
      end
    end
  end

  assign fe__mem_req  = r_req;
  assign fe__mem_addr = r_addr;
  assign fe__opcode   = r_mem[r_head];
  assign fe__valid    = w_valid;
  assign fe__pc_head  = r_head_pc;
  assign fe__js_mode  = r_js;

endmodule

`default_nettype wire
